// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the multiplexed seven-segment controller.
//   SEG_W        : width of the segment bus (dp + segments g..a)
//   DP_BIT       : bit position of the decimal point inside the segment bus
//   SEG_LUT      : active-high hex to segment map, bit 6 = g ... bit 0 = a
//   seg7_decode  : nibble -> seven segment pattern lookup
//   seg7_idx_w   : width of a digit index for a given digit count
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_W  = 8;
    localparam int DP_BIT = 7;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        return SEG_LUT[nibble];
    endfunction

    // A single-digit display still needs a one-bit index register.
    function automatic int seg7_idx_w(input int numDigits);
        return (numDigits > 1) ? $clog2(numDigits) : 1;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational hex digit to seven-segment decoder (active-high).
//   nibble_i : hex value 0..F
//   seg_o    : segments g..a, bit 6 = g, bit 0 = a
// ---------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = seg7_decode(nibble_i);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed seven-segment display controller for 1..8 digits with
// frame-synchronous (tear-free) data updates, leading-zero suppression,
// 16-level brightness PWM and selectable output polarity.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   load       : one-cycle strobe capturing data_in / dp_in
//   data_in    : packed hex nibbles, nibble i drives digit i (digit 0 = LSD)
//   dp_in      : decimal point per digit
//   lz_en      : leading-zero suppression enable, sampled live
//   bright     : brightness, on-time is (bright+1)/16 of each slot, live
//   seg_data   : bit 7 = dp, bits 6:0 = segments g..a (polarity applied)
//   dig_sel    : one-hot digit enable (polarity applied)
//   frame_done : one-cycle pulse on the last cycle of each frame
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_LOG2      = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    input  logic [3:0]              bright,
    output logic [SEG_W-1:0]        seg_data,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = seg7_idx_w(NUM_DIGITS);

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    // Prescaler value one cycle before the slot tick; used to register
    // frame_done so that it lines up with the boundary cycle itself.
    localparam logic [SCAN_LOG2-1:0] CNT_PRE  = {{(SCAN_LOG2-1){1'b1}}, 1'b0};

    logic [SCAN_LOG2-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     shadowData_q, shadowData_d;
    logic [NUM_DIGITS-1:0] shadowDp_q, shadowDp_d;
    logic                  pending_q, pending_d;
    logic [DATA_W-1:0]     activeData_q, activeData_d;
    logic [NUM_DIGITS-1:0] activeDp_q, activeDp_d;
    logic [SEG_W-1:0]      segRaw_q, segRaw_d;
    logic [NUM_DIGITS-1:0] digRaw_q, digRaw_d;
    logic                  frameDone_q, frameDone_d;

    logic                  tick;
    logic                  boundary;
    logic [NUM_DIGITS-1:0] blankMask;
    logic                  zeroRun;
    logic [3:0]            curNibble;
    logic                  curDp;
    logic [6:0]            decodedSeg;
    logic [3:0]            phase;
    logic                  digitOn;

    // Free-running prescaler and digit index. A slot ends when the
    // prescaler is all ones; the frame ends on the last slot's tick.
    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        tick        = (cnt_q == '1);
        boundary    = tick && (idx_q == LAST_IDX);
        idx_d       = idx_q;
        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        frameDone_d = (cnt_q == CNT_PRE) && (idx_q == LAST_IDX);
    end

    // Double-buffered digit data. Loads land in the shadow copy and are
    // promoted to the displayed (active) copy only on a frame boundary,
    // so a frame never mixes old and new digits. A load exactly on the
    // boundary has nothing to tear, so it goes straight to active.
    always_comb begin
        shadowData_d = shadowData_q;
        shadowDp_d   = shadowDp_q;
        pending_d    = pending_q;
        activeData_d = activeData_q;
        activeDp_d   = activeDp_q;
        if (load && boundary) begin
            shadowData_d = data_in;
            shadowDp_d   = dp_in;
            activeData_d = data_in;
            activeDp_d   = dp_in;
            pending_d    = 1'b0;
        end else begin
            if (boundary && pending_q) begin
                activeData_d = shadowData_q;
                activeDp_d   = shadowDp_q;
                pending_d    = 1'b0;
            end
            if (load) begin
                shadowData_d = data_in;
                shadowDp_d   = dp_in;
                pending_d    = 1'b1;
            end
        end
    end

    // Leading-zero mask: walk down from the most significant digit and
    // keep blanking while every nibble seen so far is zero. Digit 0 is
    // never blanked so a zero value still shows a single "0".
    always_comb begin
        blankMask = '0;
        zeroRun   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zeroRun      = zeroRun && (activeData_q[4*i +: 4] == 4'h0);
            blankMask[i] = zeroRun;
        end
    end

    always_comb begin
        curNibble = activeData_q[{idx_q, 2'b00} +: 4];
        curDp     = activeDp_q[idx_q];
    end

    seg7_hex_decode uDecode (
        .nibble_i (curNibble),
        .seg_o    (decodedSeg)
    );

    // Brightness PWM uses the top four prescaler bits as the phase within
    // the slot. While the digit is off both buses sit at their inactive
    // level; blanking by leading-zero suppression keeps the dp bit.
    always_comb begin
        phase    = cnt_q[SCAN_LOG2-1 -: 4];
        digitOn  = (phase <= bright);
        segRaw_d = '0;
        digRaw_d = '0;
        if (digitOn) begin
            segRaw_d[DP_BIT]     = curDp;
            segRaw_d[DP_BIT-1:0] = (lz_en && blankMask[idx_q]) ? 7'h00 : decodedSeg;
            digRaw_d[idx_q]      = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadowData_q <= '0;
            shadowDp_q   <= '0;
            pending_q    <= 1'b0;
            activeData_q <= '0;
            activeDp_q   <= '0;
            segRaw_q     <= '0;
            digRaw_q     <= '0;
            frameDone_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadowData_q <= shadowData_d;
            shadowDp_q   <= shadowDp_d;
            pending_q    <= pending_d;
            activeData_q <= activeData_d;
            activeDp_q   <= activeDp_d;
            segRaw_q     <= segRaw_d;
            digRaw_q     <= digRaw_d;
            frameDone_q  <= frameDone_d;
        end
    end

    // Polarity is applied after the registers, so a held reset already
    // presents the board-level inactive levels.
    assign seg_data   = segRaw_q ^ {SEG_W{SEG_ACTIVE_LOW}};
    assign dig_sel    = digRaw_q ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Scoreboard bench for seg7_scan_ctrl (4 digits, 16-cycle slots). Two
// instances share all inputs: one with active-high outputs, one with both
// polarities inverted.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int SL = 4;
    localparam int SLOT_CYC  = 16;
    localparam int FRAME_CYC = ND * SLOT_CYC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] dataIn = '0;
    logic [3:0]  dpIn = '0;
    logic        lzEn = 1'b0;
    logic [3:0]  bright = 4'hF;

    logic [7:0]  segP, segN;
    logic [3:0]  digP, digN;
    logic        fdP, fdN;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [15:0] latestData, frameData;
    logic [3:0]  latestDp, frameDp;
    logic [3:0]  curBright;
    logic        curLz;

    logic [6:0] lut [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        int         tgt;
        logic [7:0] seg;
        logic [3:0] dig;
        logic       fd;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .SCAN_LOG2(SL), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dutP (
        .clk(clk), .rst(rst), .load(load), .data_in(dataIn), .dp_in(dpIn),
        .lz_en(lzEn), .bright(bright), .seg_data(segP), .dig_sel(digP),
        .frame_done(fdP)
    );

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .SCAN_LOG2(SL), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dutN (
        .clk(clk), .rst(rst), .load(load), .data_in(dataIn), .dp_in(dpIn),
        .lz_en(lzEn), .bright(bright), .seg_data(segN), .dig_sel(digN),
        .frame_done(fdN)
    );

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %02h, expected %02h", name, cyc, act, req);
        end
    endtask

    // One clock cycle of stimulus. The model says: a frame shows the most
    // recent load made on or before the last cycle of the previous frame;
    // within a frame, slot = cycle/16, PWM phase = cycle%16.
    task automatic applyStimulus(input logic doLoad, input logic [15:0] d, input logic [3:0] dp);
        exp_t e;
        int   slot;
        int   phase;
        logic [3:0] nib;
        logic blank;
        if (cyc % FRAME_CYC == 0) begin
            frameData = latestData;
            frameDp   = latestDp;
        end
        slot  = (cyc / SLOT_CYC) % ND;
        phase = cyc % SLOT_CYC;
        nib   = frameData[4*slot +: 4];
        blank = curLz && (slot > 0) && ((frameData >> (4*slot)) == 16'h0);
        e.tgt = cyc + 1;
        e.fd  = ((cyc + 1) % FRAME_CYC == FRAME_CYC - 1);
        if (phase <= int'(curBright)) begin
            e.seg = {frameDp[slot], blank ? 7'h00 : lut[nib]};
            e.dig = 4'b0001 << slot;
        end else begin
            e.seg = 8'h00;
            e.dig = 4'b0000;
        end
        sbq.push_back(e);
        load   = doLoad;
        dataIn = d;
        dpIn   = dp;
        lzEn   = curLz;
        bright = curBright;
        if (doLoad) begin
            latestData = d;
            latestDp   = dp;
        end
        @(posedge clk);
        #2;
        load = 1'b0;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, dataIn, dpIn);
    endtask

    task automatic runUntilPhase(input int m);
        while (cyc % FRAME_CYC != m) applyStimulus(1'b0, dataIn, dpIn);
    endtask

    // Holds reset for three cycles, checking reset levels, and discards
    // any expectation (and pending load) from before the reset.
    task automatic doReset();
        rst  = 1'b1;
        load = 1'b0;
        sbq.delete();
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_seg", segP, 8'h00);
            checkOutput("rst_dig", {4'h0, digP}, 8'h00);
            checkOutput("rst_fd", {7'h0, fdP}, 8'h00);
            checkOutput("rst_segN", segN, 8'hFF);
            checkOutput("rst_digN", {4'h0, digN}, 8'h0F);
            checkOutput("rst_fdN", {7'h0, fdN}, 8'h00);
        end
        rst        = 1'b0;
        cyc        = 0;
        latestData = '0;
        latestDp   = '0;
        frameData  = '0;
        frameDp    = '0;
    endtask

    // Monitor: compares the DUT outputs against the expectation queued for
    // the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && sbq.size() > 0) begin
                if (sbq[0].tgt == cyc) begin
                    e = sbq.pop_front();
                    checkOutput("seg", segP, e.seg);
                    checkOutput("dig", {4'h0, digP}, {4'h0, e.dig});
                    checkOutput("frame_done", {7'h0, fdP}, {7'h0, e.fd});
                    checkOutput("segN", segN, ~e.seg);
                    checkOutput("digN", {4'h0, digN}, {4'h0, ~e.dig});
                    checkOutput("frame_doneN", {7'h0, fdN}, {7'h0, e.fd});
                end else if (sbq[0].tgt < cyc) begin
                    e = sbq.pop_front();
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL sync: stale expectation for cycle %0d at cycle %0d", e.tgt, cyc);
                end
            end
        end
    end

    initial begin
        curBright  = 4'hF;
        curLz      = 1'b0;
        latestData = '0;
        latestDp   = '0;
        frameData  = '0;
        frameDp    = '0;

        doReset();

        applyStimulus(1'b1, 16'h12AF, 4'h0);
        idle(200);

        runUntilPhase(20);
        applyStimulus(1'b1, 16'h3333, 4'h0);
        idle(130);

        runUntilPhase(FRAME_CYC - 1);
        curLz = 1'b1;
        applyStimulus(1'b1, 16'h0050, 4'b0100);
        idle(70);

        applyStimulus(1'b1, 16'h0000, 4'h0);
        idle(140);

        curBright = 4'd3;
        idle(130);
        curBright = 4'd0;
        idle(70);
        curBright = 4'hF;

        curLz = 1'b0;
        applyStimulus(1'b1, 16'h0008, 4'h0);
        idle(130);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 49) == 0) curBright = 4'($urandom);
            if ($urandom_range(0, 29) == 0) curLz = 1'($urandom);
            if ($urandom_range(0, 39) == 0)
                applyStimulus(1'b1, 16'($urandom), 4'($urandom));
            else if ((cyc % FRAME_CYC == FRAME_CYC - 1) && ($urandom_range(0, 2) == 0))
                applyStimulus(1'b1, 16'($urandom), 4'($urandom));
            else
                applyStimulus(1'b0, dataIn, dpIn);
        end

        curBright = 4'hF;
        curLz     = 1'b0;
        runUntilPhase(10);
        applyStimulus(1'b1, 16'hBEEF, 4'hF);
        idle(20);
        doReset();
        idle(140);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 49) == 0) curBright = 4'($urandom);
            if ($urandom_range(0, 29) == 0) curLz = 1'($urandom);
            if ($urandom_range(0, 29) == 0)
                applyStimulus(1'b1, 16'($urandom), 4'($urandom));
            else
                applyStimulus(1'b0, dataIn, dpIn);
        end

        @(negedge clk);
        #1;
        checkOutput("drain", 8'(sbq.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
